// File: rtl/control_biquad_pkg.sv
// Shared definitions for the biquad sequencer: mux select codes, FSM state
// encodings and the packed control word decoded from the state.
package control_biquad_pkg;

    // Coefficient select (controlS); SEL_ZERO is shared by all three muxes
    localparam logic [2:0] SEL_ZERO = 3'd0;
    localparam logic [2:0] SEL_A1   = 3'd1;
    localparam logic [2:0] SEL_A2   = 3'd2;
    localparam logic [2:0] SEL_B0   = 3'd3;
    localparam logic [2:0] SEL_B1   = 3'd4;
    localparam logic [2:0] SEL_B2   = 3'd5;

    // State select (controlC)
    localparam logic [1:0] SEL_FK1  = 2'd1;
    localparam logic [1:0] SEL_FK2  = 2'd2;
    localparam logic [1:0] SEL_FK   = 2'd3;

    // Addend select (controlZ)
    localparam logic [1:0] SEL_UK   = 2'd1;
    localparam logic [1:0] SEL_YK   = 2'd2;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LOAD_U = 4'd1,
        ST_MAC_A1 = 4'd2,
        ST_MAC_A2 = 4'd3,
        ST_WR_F   = 4'd4,
        ST_MAC_B0 = 4'd5,
        ST_MAC_B1 = 4'd6,
        ST_MAC_B2 = 4'd7,
        ST_WR_Y   = 4'd8,
        ST_DONE   = 4'd9
    } state_t;

    typedef struct packed {
        logic [2:0] sel_s;
        logic [1:0] sel_c;
        logic [1:0] sel_z;
        logic       acc_en;
        logic       acc_clr;
        logic       ld_fk;
        logic       ld_yk;
        logic       shift_en;
        logic       busy;
        logic       done;
    } ctrl_t;

    // States that drive the accumulator and stretch over MAC_LAT+1 cycles
    function automatic logic is_mac(input state_t s);
        return (s == ST_LOAD_U) || (s == ST_MAC_A1) || (s == ST_MAC_A2) ||
               (s == ST_MAC_B0) || (s == ST_MAC_B1) || (s == ST_MAC_B2);
    endfunction

endpackage

// File: rtl/control_biquad_if.sv
// Sequencer <-> datapath bundle: start from the sample tick, selects and
// strobes towards muxpa20/MAC/state registers, plus the FSM state for debug.
interface control_biquad_if;
    import control_biquad_pkg::*;

    // start is a valid-only pulse with no ready: it is accepted only while
    // busy==0, any start seen while busy is dropped and flagged by overrun.
    logic       start;
    logic [2:0] controlS;
    logic [1:0] controlC;
    logic [1:0] controlZ;
    logic       acc_en;
    logic       acc_clr;
    logic       ld_fk;
    logic       ld_yk;
    logic       shift_en;
    logic       busy;
    logic       done;
    logic       overrun;
    state_t     state_dbg;

    modport master (
        input  start,
        output controlS, controlC, controlZ, acc_en, acc_clr, ld_fk, ld_yk,
               shift_en, busy, done, overrun, state_dbg
    );

    modport slave (
        output start,
        input  controlS, controlC, controlZ, acc_en, acc_clr, ld_fk, ld_yk,
               shift_en, busy, done, overrun, state_dbg
    );
endinterface

// File: rtl/control_biquad_mac_wait_counter.sv
// Per-state wait counter: counts cycles spent in a MAC state and flags the
// final one; cleared on every state change, saturates at MAC_LAT.
module mac_wait_counter #(
    parameter int unsigned MAC_LAT = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic last
);
    localparam logic [2:0] LIMIT = MAC_LAT[2:0];

    logic [2:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != LIMIT)) begin
            count <= count + 3'd1;
        end
    end

    assign last = (count == LIMIT);
endmodule

// File: rtl/control_biquad.sv
// Direct-Form-II biquad sequencer: one start runs u -> f(k) -> y(k) through
// the shared MAC by stepping muxpa20 selects and accumulator/register strobes.
module control_biquad
    import control_biquad_pkg::*;
#(
    parameter int unsigned MAC_LAT = 0
) (
    input  logic             clk,
    input  logic             reset,
    control_biquad_if.master bus
);
    state_t state;
    state_t state_n;
    logic   last;
    logic   overrun_q;
    ctrl_t  ctrl;

    mac_wait_counter #(.MAC_LAT(MAC_LAT)) u_wait (
        .clk   (clk),
        .reset (reset),
        .clr   (state_n != state),
        .en    (is_mac(state)),
        .last  (last)
    );

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:   if (bus.start) state_n = ST_LOAD_U;
            ST_LOAD_U: if (last) state_n = ST_MAC_A1;
            ST_MAC_A1: if (last) state_n = ST_MAC_A2;
            ST_MAC_A2: if (last) state_n = ST_WR_F;
            ST_WR_F:   state_n = ST_MAC_B0;
            ST_MAC_B0: if (last) state_n = ST_MAC_B1;
            ST_MAC_B1: if (last) state_n = ST_MAC_B2;
            ST_MAC_B2: if (last) state_n = ST_WR_Y;
            ST_WR_Y:   state_n = ST_DONE;
            ST_DONE:   state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            overrun_q <= 1'b0;
        end else begin
            state     <= state_n;
            overrun_q <= bus.start && ctrl.busy;
        end
    end

    // Outputs depend only on the state and wait-count registers; selects are
    // held for the whole MAC state, the acc strobes fire on its final cycle.
    always_comb begin
        ctrl      = '0;
        ctrl.busy = 1'b1;
        case (state)
            ST_LOAD_U: begin
                ctrl.sel_z   = SEL_UK;
                ctrl.acc_en  = last;
                ctrl.acc_clr = last;
            end
            ST_MAC_A1: begin
                ctrl.sel_s  = SEL_A1;
                ctrl.sel_c  = SEL_FK1;
                ctrl.acc_en = last;
            end
            ST_MAC_A2: begin
                ctrl.sel_s  = SEL_A2;
                ctrl.sel_c  = SEL_FK2;
                ctrl.acc_en = last;
            end
            ST_WR_F: ctrl.ld_fk = 1'b1;
            ST_MAC_B0: begin
                ctrl.sel_s   = SEL_B0;
                ctrl.sel_c   = SEL_FK;
                ctrl.acc_en  = last;
                ctrl.acc_clr = last;
            end
            ST_MAC_B1: begin
                ctrl.sel_s  = SEL_B1;
                ctrl.sel_c  = SEL_FK1;
                ctrl.acc_en = last;
            end
            ST_MAC_B2: begin
                ctrl.sel_s  = SEL_B2;
                ctrl.sel_c  = SEL_FK2;
                ctrl.acc_en = last;
            end
            ST_WR_Y: begin
                ctrl.ld_yk    = 1'b1;
                ctrl.shift_en = 1'b1;
            end
            ST_DONE: ctrl.done = 1'b1;
            default: ctrl = '0;
        endcase
    end

    assign bus.controlS  = ctrl.sel_s;
    assign bus.controlC  = ctrl.sel_c;
    assign bus.controlZ  = ctrl.sel_z;
    assign bus.acc_en    = ctrl.acc_en;
    assign bus.acc_clr   = ctrl.acc_clr;
    assign bus.ld_fk     = ctrl.ld_fk;
    assign bus.ld_yk     = ctrl.ld_yk;
    assign bus.shift_en  = ctrl.shift_en;
    assign bus.busy      = ctrl.busy;
    assign bus.done      = ctrl.done;
    assign bus.overrun   = overrun_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_control_biquad.sv
// Bench for control_biquad: directed tables, multi-cycle corner sequences,
// closed-loop IIR check and a randomized run against a schedule model.
module tb_control_biquad;
    import control_biquad_pkg::*;

    localparam int       F  = 14;
    localparam longint   A1 = 8192;
    localparam longint   A2 = -4096;
    localparam longint   B0 = 16351;
    localparam longint   B1 = 2000;
    localparam longint   B2 = -1000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    control_biquad_if bus0 ();
    control_biquad_if bus2 ();

    control_biquad #(.MAC_LAT(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.master));
    control_biquad #(.MAC_LAT(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2.master));

    // ---------------- checking helpers ----------------
    int   n_checks = 0;
    int   n_fail   = 0;
    logic chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    // word = {S,C,Z,acc_en,acc_clr,ld_fk,ld_yk,shift_en,busy,done,overrun}
    function automatic logic [14:0] mk(input int s, input int c, input int z, input bit en,
                                       input bit clr, input bit lf, input bit ly, input bit sh,
                                       input bit bz, input bit dn, input bit ov);
        logic [2:0] s3;
        logic [1:0] c2;
        logic [1:0] z2;
        s3 = s[2:0];
        c2 = c[1:0];
        z2 = z[1:0];
        return {s3, c2, z2, en, clr, lf, ly, sh, bz, dn, ov};
    endfunction

    function automatic logic [14:0] word0();
        return {bus0.controlS, bus0.controlC, bus0.controlZ, bus0.acc_en, bus0.acc_clr,
                bus0.ld_fk, bus0.ld_yk, bus0.shift_en, bus0.busy, bus0.done, bus0.overrun};
    endfunction

    function automatic logic [14:0] word2();
        return {bus2.controlS, bus2.controlC, bus2.controlZ, bus2.acc_en, bus2.acc_clr,
                bus2.ld_fk, bus2.ld_yk, bus2.shift_en, bus2.busy, bus2.done, bus2.overrun};
    endfunction

    // ---------------- schedule model + scoreboard ----------------
    // Expected output (without overrun) at offset k>=1 after an accepted start,
    // expanded from the phase list; MAC phases last lat+1 cycles.
    function automatic logic [13:0] sched_word(input int lat, input int k);
        int t;
        t = k;
        for (int p = 0; p < 9; p++) begin
            logic [13:0] ph;
            int len;
            logic lst;
            case (p)
                0:       ph = {3'd0, 2'd0, 2'd1, 7'b1100001};
                1:       ph = {3'd1, 2'd1, 2'd0, 7'b1000001};
                2:       ph = {3'd2, 2'd2, 2'd0, 7'b1000001};
                3:       ph = {3'd0, 2'd0, 2'd0, 7'b0010000};
                4:       ph = {3'd3, 2'd3, 2'd0, 7'b1100001};
                5:       ph = {3'd4, 2'd1, 2'd0, 7'b1000001};
                6:       ph = {3'd5, 2'd2, 2'd0, 7'b1000001};
                7:       ph = {3'd0, 2'd0, 2'd0, 7'b0001100};
                default: ph = {3'd0, 2'd0, 2'd0, 7'b0000010};
            endcase
            len = ph[0] ? lat + 1 : 1;
            if (t <= len) begin
                lst = (t == len);
                return {ph[13:7], ph[6] & lst, ph[5] & lst, ph[4], ph[3], ph[2], 1'b1, ph[1]};
            end
            t -= len;
        end
        return '0;
    endfunction

    logic [13:0] exp0_q[$];
    logic [13:0] exp2_q[$];
    logic        ov0_exp = 1'b0;
    logic        ov2_exp = 1'b0;

    always @(posedge clk) begin
        if (!reset) begin
            exp0_q.delete();
            ov0_exp <= 1'b0;
        end else if (exp0_q.size() != 0) begin
            ov0_exp <= bus0.start;
            void'(exp0_q.pop_front());
        end else begin
            ov0_exp <= 1'b0;
            if (bus0.start)
                for (int k = 1; k <= 6 * 1 + 3; k++) exp0_q.push_back(sched_word(0, k));
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            exp2_q.delete();
            ov2_exp <= 1'b0;
        end else if (exp2_q.size() != 0) begin
            ov2_exp <= bus2.start;
            void'(exp2_q.pop_front());
        end else begin
            ov2_exp <= 1'b0;
            if (bus2.start)
                for (int k = 1; k <= 6 * 3 + 3; k++) exp2_q.push_back(sched_word(2, k));
        end
    end

    function automatic logic [13:0] head0();
        return (exp0_q.size() != 0) ? exp0_q[0] : 14'd0;
    endfunction

    function automatic logic [13:0] head2();
        return (exp2_q.size() != 0) ? exp2_q[0] : 14'd0;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("seq_lat0", word0(), {head0(), ov0_exp});
            check("seq_lat2", word2(), {head2(), ov2_exp});
        end
    end

    // ---------------- closed-loop datapath model on dut0 ----------------
    longint u_in = 0;
    longint acc = 0, fk = 0, fk1 = 0, fk2 = 0, yk = 0;

    function automatic longint coef(input logic [2:0] s);
        case (s)
            3'd1:    return A1;
            3'd2:    return A2;
            3'd3:    return B0;
            3'd4:    return B1;
            3'd5:    return B2;
            default: return 0;
        endcase
    endfunction

    function automatic longint cmux(input logic [1:0] c, input longint f0, input longint f1,
                                    input longint f2);
        case (c)
            2'd1:    return f1;
            2'd2:    return f2;
            2'd3:    return f0;
            default: return 0;
        endcase
    endfunction

    function automatic longint zmux(input logic [1:0] z, input longint u, input longint y);
        case (z)
            2'd1:    return u <<< F;
            2'd2:    return y <<< F;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            acc <= 0; fk <= 0; fk1 <= 0; fk2 <= 0; yk <= 0;
        end else begin
            if (bus0.acc_en)
                acc <= (bus0.acc_clr ? 64'sd0 : acc) + zmux(bus0.controlZ, u_in, yk)
                       + coef(bus0.controlS) * cmux(bus0.controlC, fk, fk1, fk2);
            if (bus0.ld_fk) fk <= acc >>> F;
            if (bus0.ld_yk) yk <= acc >>> F;
            if (bus0.shift_en) begin
                fk2 <= fk1;
                fk1 <= fk;
            end
        end
    end

    // ---------------- driver tasks ----------------
    typedef struct {
        logic        start;
        logic [14:0] exp;
    } vec_t;

    vec_t vec[12];

    task automatic run_table(input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check(nm, word0(), vec[i].exp);
            bus0.start = vec[i].start;
        end
        @(negedge clk);
        bus0.start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!bus0.busy && !bus2.busy) begin
                ok = 1;
                break;
            end
        end
        check("idle_timeout", ok, 1);
    endtask

    longint g_f1 = 0, g_f2 = 0, g_f, g_y, g_u;
    int     at, n_acc, n_clr, n_uk, first_acc, done_cyc, n_ldy;
    logic [14:0] base[11];

    initial begin
        // ---- test 1: reset held with start high ----
        reset      = 1'b0;
        bus0.start = 1'b1;
        bus2.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_out0", word0(), 15'd0);
            check("rst_out2", word2(), 15'd0);
        end
        reset      = 1'b1;
        bus0.start = 1'b0;
        bus2.start = 1'b0;
        chk_en     = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_nosq0", bus0.busy, 1'b0);
        check("rst_nosq2", bus2.busy, 1'b0);

        // ---- test 2: MAC_LAT=0 schedule table ----
        base[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        base[1]  = mk(0, 0, 1, 1, 1, 0, 0, 0, 1, 0, 0);
        base[2]  = mk(1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        base[3]  = mk(2, 2, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        base[4]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        base[5]  = mk(3, 3, 0, 1, 1, 0, 0, 0, 1, 0, 0);
        base[6]  = mk(4, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        base[7]  = mk(5, 2, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        base[8]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        base[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        base[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 11; i++) vec[i] = '{start: (i == 0), exp: base[i]};
        run_table(11, "sched_lat0");

        // ---- test 5: re-pulsed start -> overrun, restart from IDLE ----
        for (int i = 0; i < 11; i++)
            vec[i] = '{start: (i == 0 || i == 3 || i == 9 || i == 10),
                       exp: base[i] | {14'd0, (i == 4 || i == 10)}};
        vec[11] = '{start: 1'b0, exp: base[1]};
        run_table(12, "overrun");
        wait_idle(40);

        // ---- test 4: MAC_LAT=2 stretched MAC states ----
        @(negedge clk);
        bus2.start = 1'b1;
        n_acc = 0; n_clr = 0; n_uk = 0; first_acc = -1; done_cyc = -1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            bus2.start = 1'b0;
            if (bus2.acc_en) begin
                n_acc++;
                if (first_acc < 0) first_acc = c;
            end
            if (bus2.acc_clr) n_clr++;
            if (bus2.controlZ == 2'd1) n_uk++;
            if (bus2.done) done_cyc = c;
        end
        check("lat2_done_cyc", done_cyc, 21);
        check("lat2_acc_cnt", n_acc, 6);
        check("lat2_first_acc", first_acc, 3);
        check("lat2_clr_cnt", n_clr, 2);
        check("lat2_uk_hold", n_uk, 3);

        // ---- test 6: reset during MAC_B0 aborts the sample ----
        @(negedge clk);
        bus0.start = 1'b1;
        n_ldy = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            bus0.start = 1'b0;
            if (bus0.ld_yk) n_ldy++;
            if (c == 5) begin
                check("abort_in_b0", bus0.controlS, 3'd3);
                reset = 1'b0;
            end
            if (c == 6) begin
                check("abort_zero", word0(), 15'd0);
                check("abort_state", bus0.state_dbg, ST_IDLE);
                reset = 1'b1;
            end
        end
        check("abort_no_ldyk", n_ldy, 0);

        // ---- test 3: closed loop against a golden IIR ----
        for (int n = 0; n < 6; n++) begin
            g_u = (n == 0) ? 16384 : (n == 1) ? 0 : longint'($urandom_range(0, 32767)) - 16384;
            g_f = ((g_u <<< F) + A1 * g_f1 + A2 * g_f2) >>> F;
            g_y = (B0 * g_f + B1 * g_f1 + B2 * g_f2) >>> F;
            g_f2 = g_f1;
            g_f1 = g_f;
            @(negedge clk);
            u_in = g_u;
            bus0.start = 1'b1;
            at = -1;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                bus0.start = 1'b0;
                if (bus0.done) begin
                    at = i;
                    break;
                end
            end
            check("iir_done_seen", (at >= 0), 1'b1);
            @(negedge clk);
            check("iir_yk", yk, g_y);
            if (n == 0) check("iir_impulse", yk, (64'd16351 * 64'd16384) >> F);
        end

        // ---- randomized run against the schedule model ----
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            bus0.start = ($urandom_range(0, 5) == 0);
            bus2.start = ($urandom_range(0, 5) == 0);
            reset      = ($urandom_range(0, 149) != 0);
        end
        @(negedge clk);
        bus0.start = 1'b0;
        bus2.start = 1'b0;
        reset      = 1'b1;
        wait_idle(40);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
